// File: rtl/tmds_pll_pkg.sv
// Shared types and default loop-filter tables for the TMDS PLL wrapper and its
// calibration sequencer.
package tmds_pll_pkg;

    localparam int ICP_W     = 6;
    localparam int RES_W     = 3;
    localparam int CAP_W     = 2;
    localparam int DEF_N_SET = 4;

    localparam logic [DEF_N_SET*ICP_W-1:0] DEF_ICP_TABLE = {4{6'd16}};
    localparam logic [DEF_N_SET*RES_W-1:0] DEF_RES_TABLE = {4{3'd3}};
    localparam logic [DEF_N_SET*CAP_W-1:0] DEF_CAP_TABLE = {4{2'd0}};

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_LOCKED,
        ST_NEXT,
        ST_FAIL
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser, both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tmds_pll_lpf_cal.sv
// Loop-filter calibration sequencer: sweeps candidate PLL settings until one
// holds lock, then supervises lock with bounded relock retries.
module tmds_pll_lpf_cal
    import tmds_pll_pkg::*;
#(
    parameter int                     N_SET        = DEF_N_SET,
    parameter logic [N_SET*ICP_W-1:0] ICP_TABLE    = DEF_ICP_TABLE,
    parameter logic [N_SET*RES_W-1:0] RES_TABLE    = DEF_RES_TABLE,
    parameter logic [N_SET*CAP_W-1:0] CAP_TABLE    = DEF_CAP_TABLE,
    parameter int                     RESET_CYC    = 64,
    parameter int                     LOCK_TIMEOUT = 100000,
    parameter int                     STABLE_CYC   = 50000,
    parameter int                     MAX_RELOCK   = 3,
    parameter int                     SW           = (N_SET > 1) ? $clog2(N_SET) : 1,
    parameter int                     LOSS_W       = ($clog2(MAX_RELOCK + 2) > 2) ? $clog2(MAX_RELOCK + 2) : 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              auto_en,
    input  logic [SW-1:0]     set_sel,
    input  logic              restart,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [ICP_W-1:0]  icpsel,
    output logic [RES_W-1:0]  lpfres,
    output logic [CAP_W-1:0]  lpfcap,
    output logic [SW-1:0]     set_idx,
    output logic              ready,
    output logic              fail,
    output logic [LOSS_W-1:0] loss_cnt
);

    localparam int                CW       = $clog2(max3(RESET_CYC, LOCK_TIMEOUT, STABLE_CYC) + 1);
    localparam logic [CW-1:0]     RST_LAST = CW'(RESET_CYC - 1);
    localparam logic [CW-1:0]     TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]     STB_LAST = CW'(STABLE_CYC - 1);
    localparam logic [SW-1:0]     LAST_IDX = SW'(N_SET - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

    state_t              state, state_n;
    logic [CW-1:0]       cnt;
    logic                lock_s, clr, cnt_en;
    logic                auto_q, auto_n, relock_q, relock_n;
    logic                ready_n, fail_n, pll_reset_n;
    logic [SW-1:0]       idx_n, load_idx;
    logic [LOSS_W-1:0]   loss_n;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign load_idx = auto_en ? '0 : ((set_sel > LAST_IDX) ? LAST_IDX : set_sel);

    always_comb begin
        state_n  = state;
        idx_n    = set_idx;
        auto_n   = auto_q;
        relock_n = relock_q;
        ready_n  = ready;
        loss_n   = loss_cnt;
        case (state)
            ST_RST:       if (cnt == RST_LAST) state_n = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s)               state_n = ST_STABLE;
                else if (cnt == TO_LAST)  state_n = ST_NEXT;
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_n = ST_NEXT;
                end else if (cnt == STB_LAST) begin
                    state_n = ST_LOCKED;
                    ready_n = 1'b1;
                    // Relock qualifications keep the running loss count so retries stay bounded.
                    if (!relock_q) loss_n = '0;
                end
            end
            ST_LOCKED: begin
                if (!lock_s) begin
                    ready_n  = 1'b0;
                    relock_n = 1'b1;
                    if (loss_cnt != LOSS_MAX) loss_n = loss_cnt + 1'b1;
                    state_n = (int'(loss_cnt) >= MAX_RELOCK) ? ST_FAIL : ST_RST;
                end
            end
            ST_NEXT: begin
                relock_n = 1'b0;
                if (auto_q && (set_idx != LAST_IDX)) begin
                    idx_n   = set_idx + 1'b1;
                    state_n = ST_RST;
                end else begin
                    state_n = ST_FAIL;
                end
            end
            default: ;
        endcase
        if (restart) begin
            state_n  = ST_RST;
            idx_n    = load_idx;
            auto_n   = auto_en;
            relock_n = 1'b0;
            ready_n  = 1'b0;
            loss_n   = '0;
        end
        fail_n      = (state_n == ST_FAIL);
        pll_reset_n = (state_n == ST_RST) || (state_n == ST_FAIL);
        clr         = (state_n != state) || restart;
        cnt_en      = (state == ST_RST) || (state == ST_WAIT_LOCK) || (state == ST_STABLE);
    end

    // Power-on behaves like an auto sweep starting from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RST;
            cnt       <= '0;
            set_idx   <= '0;
            auto_q    <= 1'b1;
            relock_q  <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            pll_reset <= 1'b1;
            loss_cnt  <= '0;
        end else begin
            state     <= state_n;
            set_idx   <= idx_n;
            auto_q    <= auto_n;
            relock_q  <= relock_n;
            ready     <= ready_n;
            fail      <= fail_n;
            pll_reset <= pll_reset_n;
            loss_cnt  <= loss_n;
            if (clr)         cnt <= '0;
            else if (cnt_en) cnt <= cnt + 1'b1;
        end
    end

    // Codes trail set_idx by one cycle, so they settle in the first RST cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icpsel <= ICP_TABLE[ICP_W-1:0];
            lpfres <= RES_TABLE[RES_W-1:0];
            lpfcap <= CAP_TABLE[CAP_W-1:0];
        end else begin
            icpsel <= ICP_TABLE[int'(set_idx)*ICP_W +: ICP_W];
            lpfres <= RES_TABLE[int'(set_idx)*RES_W +: RES_W];
            lpfcap <= CAP_TABLE[int'(set_idx)*CAP_W +: CAP_W];
        end
    end

endmodule
